mux_serializer: RTL and testbench

Parallel-to-serial transmitter that directly drives the existing 16-to-1 bit multiplexer. It captures a 16-bit word on a start strobe and steps a 4-bit select counter through all 16 positions, one per clock, in either LSB-first or MSB-first order. It emits the multiplexer output as a qualified serial stream and pulses a completion flag. It replaces the manual select stepping used when bringing the multiplexer up.

---
 rtl/mux_serializer_pkg.sv | 31 +++
 rtl/mux_serializer_mux16.sv | 19 +
 rtl/mux_serializer.sv | 153 +++++++++++++++
 tb/tb_mux_serializer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
// mux_serializer_pkg
//   Shared constants and types for the mux_serializer parallel-to-serial
//   transmitter and its 16-to-1 bit multiplexer.
//   WORD_W   : transmitted word width (16)
//   SEL_W    : multiplexer select width (4)
//   LAST_BIT : bit count value of the final bit of a frame
//   state_t  : transmitter FSM states
package mux_serializer_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_BIT = 5'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Select value for the first bit of a frame in the requested order.
  function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
    if (msb_first) begin
      return 4'd15;
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/mux_serializer_mux16.sv
// MUX16to1
//   Existing 16-to-1 single-bit multiplexer driven by the serializer.
//   data : 16 input bits
//   sel  : 4-bit select, chooses data[sel]
//   y    : selected bit (purely combinational)
module MUX16to1
  import mux_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  // Pure bit selection; no state.
  always_comb begin
    y = data[sel];
  end

endmodule

// File: rtl/mux_serializer.sv
// mux_serializer
//   Captures a 16-bit word on a start strobe and walks the MUX16to1 select
//   through all 16 positions (LSB-first or MSB-first), one per clock,
//   presenting the multiplexer output as a qualified serial stream.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   start     : frame request, honoured only in IDLE or DONE
//   msb_first : bit order, captured with data_in on accept
//   data_in   : word to transmit, captured on accept
//   ser_out   : current serial bit, forced to 0 when ser_valid is low
//   ser_valid : high while a frame bit is on ser_out (same as busy)
//   busy      : high in SHIFT
//   done      : one-cycle pulse in the DONE state
//   sel       : current multiplexer select (observe only)
module mux_serializer
  import mux_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              msb_first,
  input  logic [WORD_W-1:0] data_in,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  sel
);

  state_t              state_r;
  state_t              state_next_s;
  logic [WORD_W-1:0]   word_r;
  logic                order_r;
  logic [SEL_W-1:0]    sel_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;
  logic                accept_s;
  logic                step_s;
  logic                raw_bit_s;

  // Start is only honoured once the previous frame has finished.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == SHIFT) && (cnt_r != LAST_BIT)) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  // Next-state logic for the transmitter FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture registers plus bit counter and select stepping; sel never
  // wraps because stepping stops on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r  <= 16'h0000;
      order_r <= 1'b0;
      sel_r   <= 4'd0;
      cnt_r   <= 5'd0;
    end else if (accept_s) begin
      word_r  <= data_in;
      order_r <= msb_first;
      sel_r   <= first_sel(msb_first);
      cnt_r   <= 5'd0;
    end else if (step_s) begin
      cnt_r <= cnt_r + 5'd1;
      if (order_r) begin
        sel_r <= sel_r - 4'd1;
      end else begin
        sel_r <= sel_r + 4'd1;
      end
    end else begin
      word_r  <= word_r;
      order_r <= order_r;
      sel_r   <= sel_r;
      cnt_r   <= cnt_r;
    end
  end

  // Status flags registered from the next state so they track state_r
  // exactly while clearing asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == SHIFT);
      done_r <= (state_next_s == DONE);
    end
  end

  MUX16to1 u_mux (
    .data (word_r),
    .sel  (sel_r),
    .y    (raw_bit_s)
  );

  // Serial output is the raw mux bit qualified by the busy flag.
  always_comb begin
    ser_out   = raw_bit_s & busy_r;
    ser_valid = busy_r;
    busy      = busy_r;
    done      = done_r;
    sel       = sel_r;
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer
//   Self-checking bench for mux_serializer. Expected streams come from a
//   simple model: bit i of a frame is word[i] (LSB-first) or word[15-i]
//   (MSB-first), and the select presented with it is i or 15-i.
module tb_mux_serializer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        msb_first;
  logic [15:0] data_in;
  logic        ser_out;
  logic        ser_valid;
  logic        busy;
  logic        done;
  logic [3:0]  sel;

  int checks;
  int errors;

  mux_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msb_first (msb_first),
    .data_in   (data_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: serial stream of a word, index 0 transmitted first.
  function automatic logic [15:0] model_stream(input logic [15:0] w, input logic ord);
    logic [15:0] s;
    for (int i = 0; i < 16; i++) begin
      s[i] = ord ? w[15 - i] : w[i];
    end
    return s;
  endfunction

  function automatic logic [3:0] model_sel(input int i, input logic ord);
    int v;
    v = ord ? (15 - i) : i;
    return v[3:0];
  endfunction

  // Sends one frame and records what the DUT shows for its 16 bit cycles
  // and the following DONE cycle. Returns at the negedge inside DONE.
  task automatic do_frame(input logic [15:0] w, input logic ord,
                          output logic [15:0] bits, output logic [63:0] sels,
                          output int valid_cnt, output logic done_during,
                          output logic done_after, output logic busy_after,
                          output logic [3:0] sel_after);
    valid_cnt   = 0;
    done_during = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    data_in   = w;
    msb_first = ord;
    @(negedge clk);
    start     = 1'b0;
    data_in   = 16'($urandom);
    msb_first = 1'($urandom);
    for (int i = 0; i < 16; i++) begin
      bits[i]          = ser_out;
      sels[i*4 +: 4]   = sel;
      if (ser_valid && busy) valid_cnt++;
      if (done) done_during = 1'b1;
      @(negedge clk);
    end
    done_after = done;
    busy_after = busy | ser_valid | ser_out;
    sel_after  = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    msb_first = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({ser_out, ser_valid, busy, done, sel} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000000", {ser_out, ser_valid, busy, done, sel});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy/done %b expected 00", {busy, done});
    end
  endtask

  // Frame with a known word and order, compared against the model and the
  // explicitly listed stream.
  task automatic test_known(input logic [15:0] w, input logic ord,
                            input logic [15:0] listed, input string name);
    logic [15:0] bits;
    logic [63:0] sels;
    int          vc;
    logic        dd, da, ba;
    logic [3:0]  sa;
    do_frame(w, ord, bits, sels, vc, dd, da, ba, sa);
    checks++;
    if (bits !== model_stream(w, ord)) begin
      errors++;
      $display("FAIL %s_bits got %h expected %h", name, bits, model_stream(w, ord));
    end
    checks++;
    if (bits !== listed) begin
      errors++;
      $display("FAIL %s_listed got %h expected %h", name, bits, listed);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sels[i*4 +: 4] !== model_sel(i, ord)) begin
        errors++;
        $display("FAIL %s_sel%0d got %0d expected %0d", name, i, sels[i*4 +: 4], model_sel(i, ord));
      end
    end
    checks++;
    if (vc != 16 || dd !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid got valid_cycles %0d done_in_frame %b expected 16 0", name, vc, dd);
    end
    checks++;
    if (da !== 1'b1 || ba !== 1'b0 || sa !== model_sel(15, ord)) begin
      errors++;
      $display("FAIL %s_done got done %b busy %b sel %0d expected 1 0 %0d", name, da, ba, sa, model_sel(15, ord));
    end
    @(negedge clk);
    checks++;
    if ({done, busy, ser_valid, ser_out} !== 4'b0000 || sel !== model_sel(15, ord)) begin
      errors++;
      $display("FAIL %s_idle got dbvo %b sel %0d expected 0000 %0d", name, {done, busy, ser_valid, ser_out}, sel, model_sel(15, ord));
    end
  endtask

  task automatic test_random();
    logic [15:0] w, bits;
    logic        ord;
    logic [63:0] sels;
    int          vc;
    logic        dd, da, ba;
    logic [3:0]  sa;
    for (int k = 0; k < 8; k++) begin
      w   = 16'($urandom);
      ord = 1'($urandom);
      do_frame(w, ord, bits, sels, vc, dd, da, ba, sa);
      checks++;
      if (bits !== model_stream(w, ord) || vc != 16 || da !== 1'b1) begin
        errors++;
        $display("FAIL random%0d got bits %h valid %0d done %b expected %h 16 1", k, bits, vc, da, model_stream(w, ord));
      end
      checks++;
      if (sels[3:0] !== model_sel(0, ord) || sels[63:60] !== model_sel(15, ord)) begin
        errors++;
        $display("FAIL random%0d_sel got first %0d last %0d", k, sels[3:0], sels[63:60]);
      end
    end
  endtask

  // Start, new data and new order during SHIFT must not disturb the frame.
  task automatic test_ignore();
    logic [15:0] w, bits, exp;
    int          dcnt;
    w    = 16'h0015;
    exp  = model_stream(w, 1'b0);
    dcnt = 0;
    @(negedge clk);
    start = 1'b1; data_in = w; msb_first = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        start = 1'b1; data_in = 16'hFFFF; msb_first = 1'b1;
      end
      if (i == 15) start = 1'b0;
      bits[i] = ser_out;
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (bits !== exp || dcnt != 0) begin
      errors++;
      $display("FAIL ignore_bits got %h early_done %0d expected %h 0", bits, dcnt, exp);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done got done %b busy %b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_restart got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  // Start held high: frames repeat with one DONE cycle between them.
  task automatic test_back_to_back();
    logic [15:0] exp;
    int          p, bad;
    exp = model_stream(16'h8001, 1'b0);
    bad = 0;
    @(negedge clk);
    start = 1'b1; data_in = 16'h8001; msb_first = 1'b0;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      if (k == 50) start = 1'b0;
      p = k % 17;
      checks++;
      if (p < 16) begin
        if (ser_valid !== 1'b1 || done !== 1'b0 || ser_out !== exp[p]) begin
          errors++; bad++;
          $display("FAIL b2b_cycle%0d got v %b d %b o %b expected 1 0 %b", k, ser_valid, done, ser_out, exp[p]);
        end
      end else begin
        if (ser_valid !== 1'b0 || done !== 1'b1 || ser_out !== 1'b0) begin
          errors++; bad++;
          $display("FAIL b2b_done%0d got v %b d %b o %b expected 0 1 0", k, ser_valid, done, ser_out);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  // Asynchronous reset in the middle of a frame.
  task automatic test_reset_mid();
    logic [15:0] w, bits;
    logic [63:0] sels;
    int          vc, dcnt;
    logic        dd, da, ba;
    logic [3:0]  sa;
    w = 16'hFFFF;
    @(negedge clk);
    start = 1'b1; data_in = w; msb_first = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ser_out !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_before got busy %b out %b expected 1 1", busy, ser_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, ser_valid, ser_out, done} !== 4'b0000 || sel !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async got bvod %b sel %0d expected 0000 0", {busy, ser_valid, ser_out, done}, sel);
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL rstmid_idle got active_cycles %0d expected 0", dcnt);
    end
    w = 16'h3C5A;
    do_frame(w, 1'b0, bits, sels, vc, dd, da, ba, sa);
    checks++;
    if (bits !== model_stream(w, 1'b0) || vc != 16 || da !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_restart got bits %h valid %0d done %b expected %h 16 1", bits, vc, da, model_stream(w, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_known(16'h5555, 1'b0, 16'h5555, "lsb5555");
    test_known(16'hB7BB, 1'b1, 16'b1101_1101_1110_1101, "msbB7BB");
    test_known(16'h040E, 1'b0, 16'b0000_0100_0000_1110, "lsb1038");
    test_random();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
